// File: rtl/instr_encoder.sv
// ============================================================================
// Module      : instr_encoder
// Description : Encodes RV32 I/S/SB/UJ/U instruction words from discrete
//               fields and expands the LI pseudo-op into ADDI, LUI or a
//               LUI+ADDI pair. Valid/ready on both sides, one-cycle latency.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module instr_encoder #(
  parameter int INSTRUCTION = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [2:0]             req_fmt,
  input  logic [6:0]             req_opcode,
  input  logic [2:0]             req_funct3,
  input  logic [4:0]             req_rd,
  input  logic [4:0]             req_rs1,
  input  logic [4:0]             req_rs2,
  input  logic [INSTRUCTION-1:0] req_imm,
  output logic                   instr_valid,
  input  logic                   instr_ready,
  output logic [INSTRUCTION-1:0] instruction,
  output logic                   imm_err
);

  localparam logic [2:0] FMT_I  = 3'd0;
  localparam logic [2:0] FMT_S  = 3'd1;
  localparam logic [2:0] FMT_SB = 3'd2;
  localparam logic [2:0] FMT_UJ = 3'd3;
  localparam logic [2:0] FMT_U  = 3'd4;
  localparam logic [2:0] FMT_LI = 3'd5;

  localparam logic [6:0]  OP_OPIMM = 7'h13;
  localparam logic [6:0]  OP_LUI   = 7'h37;
  localparam logic [31:0] NOP_WORD = 32'h0000_0013;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_EMIT  = 2'd1,
    S_EMIT2 = 2'd2
  } state_t;

  state_t      state, state_d;

  // Second-word context for a two-word LI (ADDI rd,rd,lo)
  logic        pending, pending_d;
  logic [4:0]  li_rd, li_rd_d;
  logic [11:0] li_lo, li_lo_d;

  logic [31:0] instruction_d;
  logic        imm_err_d;
  logic        instr_valid_d;

  // Combinational encoding of the request currently on the inputs
  logic [31:0] enc_word;
  logic        enc_err;
  logic        enc_pend;

  logic        fits12;
  logic        fits13;
  logic        fits21;
  logic [31:0] hi_sum;
  logic [31:0] second_word;
  logic        accept;

  assign fits12 = (req_imm[31:11] == {21{req_imm[11]}});
  assign fits13 = (req_imm[31:12] == {20{req_imm[12]}});
  assign fits21 = (req_imm[31:20] == {12{req_imm[20]}});

  // Rounded upper part so that the sign-extended ADDI low part lands exactly
  assign hi_sum = req_imm + 32'h0000_0800;

  assign second_word = {li_lo, li_rd, 3'b000, li_rd, OP_OPIMM};

  // Ready while idle, or when the current word leaves this cycle and no
  // LI second word still has to follow it; never during reset
  assign req_ready = rst_n && ((state == S_IDLE) || (instr_ready && !pending));
  assign accept    = req_valid && req_ready;

  // Format-dependent encoding and range checking of the input request
  always_comb begin
    enc_word = NOP_WORD;
    enc_err  = 1'b1;
    enc_pend = 1'b0;
    case (req_fmt)
      FMT_I: begin
        enc_word = {req_imm[11:0], req_rs1, req_funct3, req_rd, req_opcode};
        enc_err  = !fits12;
      end
      FMT_S: begin
        enc_word = {req_imm[11:5], req_rs2, req_rs1, req_funct3, req_imm[4:0], req_opcode};
        enc_err  = !fits12;
      end
      FMT_SB: begin
        enc_word = {req_imm[12], req_imm[10:5], req_rs2, req_rs1, req_funct3,
                    req_imm[4:1], req_imm[11], req_opcode};
        enc_err  = !fits13 || req_imm[0];
      end
      FMT_UJ: begin
        enc_word = {req_imm[20], req_imm[10:1], req_imm[11], req_imm[19:12], req_rd, req_opcode};
        enc_err  = !fits21 || req_imm[0];
      end
      FMT_U: begin
        enc_word = {req_imm[31:12], req_rd, req_opcode};
        enc_err  = (req_imm[11:0] != 12'd0);
      end
      FMT_LI: begin
        enc_err = 1'b0;
        if (fits12) begin
          enc_word = {req_imm[11:0], 5'd0, 3'b000, req_rd, OP_OPIMM};
        end else if (req_imm[11:0] == 12'd0) begin
          enc_word = {req_imm[31:12], req_rd, OP_LUI};
        end else begin
          enc_word = {hi_sum[31:12], req_rd, OP_LUI};
          enc_pend = 1'b1;
        end
      end
      default: begin
        enc_word = NOP_WORD;
        enc_err  = 1'b1;
      end
    endcase
  end

  // Next-state and next output-register values
  always_comb begin
    state_d       = state;
    pending_d     = pending;
    li_rd_d       = li_rd;
    li_lo_d       = li_lo;
    instruction_d = instruction;
    imm_err_d     = imm_err;
    instr_valid_d = instr_valid;
    case (state)
      S_IDLE, S_EMIT2, S_EMIT: begin
        if ((state == S_IDLE) || instr_ready) begin
          if (pending) begin
            instruction_d = second_word;
            imm_err_d     = 1'b0;
            pending_d     = 1'b0;
            state_d       = S_EMIT2;
          end else if (accept) begin
            instruction_d = enc_word;
            imm_err_d     = enc_err;
            pending_d     = enc_pend;
            li_rd_d       = req_rd;
            li_lo_d       = req_imm[11:0];
            instr_valid_d = 1'b1;
            state_d       = S_EMIT;
          end else begin
            instr_valid_d = 1'b0;
            state_d       = S_IDLE;
          end
        end
      end
      default: begin
        instr_valid_d = 1'b0;
        pending_d     = 1'b0;
        state_d       = S_IDLE;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pending     <= 1'b0;
      li_rd       <= 5'd0;
      li_lo       <= 12'd0;
      instruction <= '0;
      imm_err     <= 1'b0;
      instr_valid <= 1'b0;
    end else begin
      state       <= state_d;
      pending     <= pending_d;
      li_rd       <= li_rd_d;
      li_lo       <= li_lo_d;
      instruction <= instruction_d;
      imm_err     <= imm_err_d;
      instr_valid <= instr_valid_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_instr_encoder.sv
// ============================================================================
// Module      : tb_instr_encoder
// Description : Scoreboard bench for instr_encoder with directed vectors.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_instr_encoder;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_fmt;
  logic [6:0]  req_opcode;
  logic [2:0]  req_funct3;
  logic [4:0]  req_rd;
  logic [4:0]  req_rs1;
  logic [4:0]  req_rs2;
  logic [31:0] req_imm;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instruction;
  logic        imm_err;

  int checks   = 0;
  int failures = 0;

  logic [32:0] exp_q[$];   // {imm_err, instruction}

  instr_encoder #(.INSTRUCTION(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_fmt     (req_fmt),
    .req_opcode  (req_opcode),
    .req_funct3  (req_funct3),
    .req_rd      (req_rd),
    .req_rs1     (req_rs1),
    .req_rs2     (req_rs2),
    .req_imm     (req_imm),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instruction (instruction),
    .imm_err     (imm_err)
  );

  always #5 clk = ~clk;

  // Monitor: every output handshake pops one expected word
  always @(negedge clk) begin
    if (rst_n && instr_valid && instr_ready) begin
      logic [32:0] e;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_word got=%h err=%0b", instruction, imm_err);
      end else begin
        e = exp_q.pop_front();
        if ({imm_err, instruction} !== e) begin
          failures++;
          $display("FAIL word got=%h err=%0b exp=%h err=%0b", instruction, imm_err, e[31:0], e[32]);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", name, got, exp);
    end
  endtask

  task automatic push(input logic [31:0] w, input logic e);
    exp_q.push_back({e, w});
  endtask

  // Present a request and return just after the edge that accepts it
  task automatic drive(input logic [2:0] f, input logic [6:0] op, input logic [2:0] f3,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    int n;
    req_valid  = 1'b1;
    req_fmt    = f;
    req_opcode = op;
    req_funct3 = f3;
    req_rd     = rd;
    req_rs1    = rs1;
    req_rs2    = rs2;
    req_imm    = imm;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!req_ready && n < 200);
    if (!req_ready) begin
      checks++;
      failures++;
      $display("FAIL accept_timeout got=0 exp=1");
    end
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    req_valid   = 1'b0;
    instr_ready = 1'b1;
    n = 0;
    while ((exp_q.size() != 0 || instr_valid) && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    checks++;
    if (exp_q.size() != 0 || instr_valid) begin
      failures++;
      $display("FAIL drain_timeout got=%0d exp=0", exp_q.size());
    end
  endtask

  initial begin
    rst_n       = 1'b0;
    req_valid   = 1'b1;
    instr_ready = 1'b1;
    req_fmt     = 3'd6;
    req_opcode  = 7'h0;
    req_funct3  = 3'd0;
    req_rd      = 5'd0;
    req_rs1     = 5'd0;
    req_rs2     = 5'd0;
    req_imm     = 32'h0;

    // Reset state, with a request held high to show it is not accepted
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'h0);
    check("rst_err",   {31'd0, imm_err}, 32'd0);
    check("rst_ready", {31'd0, req_ready}, 32'd0);
    req_valid = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst_valid", {31'd0, instr_valid}, 32'd0);

    // I format, one-cycle latency
    push(32'hFFF10093, 1'b0);
    drive(3'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
    req_valid = 1'b0;
    check("lat_valid", {31'd0, instr_valid}, 32'd1);
    check("lat_instr", instruction, 32'hFFF10093);

    // Back-to-back directed vectors
    push(32'h00208463, 1'b0);
    drive(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd8);          // SB ok
    push(32'h00208463, 1'b1);
    drive(3'd2, 7'h63, 3'd0, 5'd0, 5'd1, 5'd2, 32'd9);          // SB odd
    push(32'h80010093, 1'b1);
    drive(3'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'h800);        // I overflow
    push(32'hFE312E23, 1'b0);
    drive(3'd1, 7'h23, 3'd2, 5'd0, 5'd2, 5'd3, 32'hFFFF_FFFC);  // S -4
    push(32'h001000EF, 1'b0);
    drive(3'd3, 7'h6F, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800);        // UJ
    push(32'h123453B7, 1'b0);
    drive(3'd4, 7'h37, 3'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5000);  // U ok
    push(32'h123453B7, 1'b1);
    drive(3'd4, 7'h37, 3'd0, 5'd7, 5'd0, 5'd0, 32'h1234_5001);  // U low bits
    push(32'h00000013, 1'b1);
    drive(3'd6, 7'h33, 3'd1, 5'd9, 5'd9, 5'd9, 32'h1);          // reserved
    push(32'h00500193, 1'b0);
    drive(3'd5, 7'h7F, 3'd7, 5'd3, 5'd4, 5'd5, 32'd5);          // LI small
    push(32'h12345137, 1'b0);
    drive(3'd5, 7'h00, 3'd0, 5'd2, 5'd0, 5'd0, 32'h1234_5000);  // LI LUI only
    push(32'h80000093, 1'b0);
    drive(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'hFFFF_F800);  // LI -2048
    push(32'h000010B7, 1'b0);
    push(32'h80008093, 1'b0);
    drive(3'd5, 7'h00, 3'd0, 5'd1, 5'd0, 5'd0, 32'h800);        // LI pair
    drain();

    // Stall during EMIT of a two-word LI, then resume with no bubble
    instr_ready = 1'b0;
    push(32'h123462B7, 1'b0);
    push(32'hFFF28293, 1'b0);
    drive(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    req_valid  = 1'b1;
    req_fmt    = 3'd0;
    req_opcode = 7'h13;
    req_funct3 = 3'd0;
    req_rd     = 5'd1;
    req_rs1    = 5'd2;
    req_imm    = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("stall_valid", {31'd0, instr_valid}, 32'd1);
      check("stall_instr", instruction, 32'h123462B7);
      check("stall_ready", {31'd0, req_ready}, 32'd0);
    end
    @(posedge clk);
    #1;
    instr_ready = 1'b1;
    push(32'hFFF10093, 1'b0);
    push(32'h00500193, 1'b0);
    fork
      begin
        drive(3'd0, 7'h13, 3'd0, 5'd1, 5'd2, 5'd0, 32'hFFFF_FFFF);
        drive(3'd5, 7'h00, 3'd0, 5'd3, 5'd0, 5'd0, 32'd5);
        req_valid = 1'b0;
      end
      begin
        for (int i = 0; i < 4; i++) begin
          @(negedge clk);
          check("b2b_valid", {31'd0, instr_valid}, 32'd1);
        end
      end
    join
    drain();

    // Reset while the LUI of a two-word LI waits in EMIT
    instr_ready = 1'b0;
    drive(3'd5, 7'h00, 3'd0, 5'd5, 5'd0, 5'd0, 32'h1234_5FFF);
    req_valid = 1'b0;
    @(negedge clk);
    check("pre_rst_valid", {31'd0, instr_valid}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    check("mid_rst_valid", {31'd0, instr_valid}, 32'd0);
    instr_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_addi_valid", {31'd0, instr_valid}, 32'd0);
    end

    check("queue_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time limit
  initial begin
    #200000;
    $display("FAIL global_timeout got=running exp=finished");
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/instr_encoder.md
INSTR_ENCODER -- requirements
Module: instr_encoder

Interface
REQ-001 SHALL have parameter INSTRUCTION, default 32, instruction word width; only 32 is supported.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, synchronous, active-low.
REQ-004 SHALL have port req_valid  input  1  encode request present.
REQ-005 SHALL have port req_ready  output  1  request accepted when high with req_valid.
REQ-006 SHALL have port req_fmt  input  3  format: 0=I, 1=S, 2=SB, 3=UJ, 4=U, 5=LI pseudo-op; 6-7 reserved.
REQ-007 SHALL have ports req_opcode (input, 7), req_funct3 (input, 3), req_rd, req_rs1 and req_rs2 (input, 5 each) as instruction fields.
REQ-008 SHALL have port req_imm  input  INSTRUCTION  signed byte-offset or constant.
REQ-009 SHALL have port instr_valid  output  1  instruction word present.
REQ-010 SHALL have port instr_ready  input  1  consumer accepts the word when high with instr_valid.
REQ-011 SHALL have port instruction  output  INSTRUCTION  encoded word, registered.
REQ-012 SHALL have port imm_err  output  1  immediate out of range for the format; qualified by instr_valid.

Function
REQ-013 SHALL implement an FSM with states IDLE, EMIT and EMIT2; req_ready=1 in IDLE, and req_ready=1 in EMIT/EMIT2 when instr_ready=1 and no second word is pending.
REQ-014 SHALL register the word on the accepting edge: a request accepted at edge N gives instr_valid=1 after edge N, so latency is 1 cycle.
REQ-015 SHALL encode I as {imm[11:0],rs1,funct3,rd,opcode}.
REQ-016 SHALL encode S as {imm[11:5],rs2,rs1,funct3,imm[4:0],opcode}.
REQ-017 SHALL encode SB as {imm[12],imm[10:5],rs2,rs1,funct3,imm[4:1],imm[11],opcode}.
REQ-018 SHALL encode UJ as {imm[20],imm[10:1],imm[11],imm[19:12],rd,opcode}.
REQ-019 SHALL encode U as {imm[31:12],rd,opcode}.
REQ-020 SHALL set imm_err=1 for each out-of-range format, encode the truncated fields anyway, and not stall:
- I/S: imm not a 12-bit sign extension.
- SB: imm not a 13-bit sign extension, or imm[0]=1.
- UJ: imm not a 21-bit sign extension, or imm[0]=1.
- U: imm[11:0] not equal to 0.
- Reserved fmt: emit 0x00000013 (NOP) with imm_err=1.
REQ-021 SHALL expand LI (ignoring req_opcode, funct3, rs1 and rs2) by imm value:
- imm fits 12-bit signed: one word, ADDI rd,x0,imm (opcode 0x13, funct3 0).
- imm[11:0]=0: one word, LUI rd,imm[31:12] (opcode 0x37).
- Otherwise: LUI rd,hi then ADDI rd,rd,imm[11:0], where hi=(imm+0x800)>>12 truncated to 20 bits (mod 2^32).
- LI imm_err is always 0.
REQ-022 SHALL move EMIT to EMIT2 on instr_ready when a second LI word is pending, loading the ADDI word; EMIT2 returns to IDLE on instr_ready, or stays in EMIT on a simultaneous new accept.
REQ-023 SHALL, when handshake-out and a new accept coincide, load the new word in the same edge so instr_valid stays 1 (back-to-back, one word/cycle).
REQ-024 SHALL hold instruction, imm_err and instr_valid stable while instr_valid=1 and instr_ready=0.
REQ-025 SHALL take the first word of a request from one input sample and latch rd and imm[11:0] for EMIT2; inputs need not be held after accept.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, set state=IDLE, instr_valid=0, instruction=0, imm_err=0 and pending flag=0, and keep req_ready=0 during reset.
REQ-027 SHALL, on reset mid-operation, discard any pending LI second word; nothing is emitted after reset release until a new request.

Verification
REQ-028 SHALL pass: I fmt, opcode 0x13, f3 0, rd 1, rs1 2, imm 0xFFFFFFFF -> instruction 0xFFF10093, imm_err 0, one cycle after accept.
REQ-029 SHALL pass: SB fmt, opcode 0x63, f3 0, rs1 1, rs2 2, imm 8 -> 0x00208463; same with imm 9 -> imm_err 1.
REQ-030 SHALL pass: LI rd 5, imm 0x12345FFF -> 0x123462B7 then 0xFFF28293 on consecutive handshakes; LI rd 3, imm 5 -> single 0x00500193.
REQ-031 SHALL pass: I fmt rd 1, rs1 2, imm 0x800 -> 0x80010093 with imm_err 1.
REQ-032 SHALL pass: instr_ready low 3 cycles during EMIT -> word and instr_valid stable and req_ready 0, then with instr_ready high and req_valid high -> back-to-back words with no bubble.
REQ-033 SHALL pass: rst_n low for 1 cycle while LUI of a two-word LI is in EMIT -> instr_valid 0 next cycle and no ADDI ever emitted.
